// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core pipeline.
// Holds the fetch FSM encoding, the bubble instruction and the IF/ID bundle.
package core_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, hold (default) and flush to a bubble.
// Ports: clk, rst_n, flush, load, d (next bundle), q (registered bundle).
module if_id_reg
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   load,
    input  if_id_t d,
    output if_id_t q
);

    // Flush outranks load; holding is the default.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '{1'b0, '0, NOP_INSTR};
        end else if (flush) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, one-outstanding imem req/gnt/rvalid FSM, stall hold buffer.
// Ports: clk/rst_n, stall, redirect_*, imem_* bus, registered if_id_* outputs.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [4:0]  if_id_rs1_idx,
    output logic [4:0]  if_id_rs2_idx
);

    fetch_state_e state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_pc_q, hold_instr_q;
    logic        hold_we;

    logic        ifid_load;
    if_id_t      ifid_d, ifid_q;

    logic [31:0] redir_pc;
    logic [31:0] pc_inc;

    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
    assign pc_inc   = pc_q + 32'd4;

    // State, PC and hold buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            hold_pc_q    <= '0;
            hold_instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (hold_we) begin
                hold_pc_q    <= pc_q;
                hold_instr_q <= imem_rdata;
            end
        end
    end

    // Next state, next PC and IF/ID load control.
    // Redirect beats stall beats load in every state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hold_we   = 1'b0;
        ifid_load = 1'b0;
        ifid_d    = '{1'b1, pc_q, imem_rdata};
        unique case (state_q)
            REQ: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (imem_gnt) state_d = DROP;
                end else if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    if (stall) begin
                        hold_we = 1'b1;
                        state_d = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_d      = pc_inc;
                        state_d   = REQ;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = REQ;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    ifid_d    = '{1'b1, hold_pc_q, hold_instr_q};
                    pc_d      = pc_inc;
                    state_d   = REQ;
                end
            end
            DROP: begin
                if (redirect_valid) pc_d = redir_pc;
                // The response to the abandoned request still has to drain.
                if (imem_rvalid) state_d = REQ;
            end
            default: state_d = REQ;
        endcase
    end

    // Bus outputs; no request is presented while reset is held.
    always_comb begin
        imem_req  = rst_n && (state_q == REQ);
        imem_addr = pc_q;
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .load  (ifid_load),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign if_id_valid   = ifid_q.valid;
    assign if_id_pc      = ifid_q.pc;
    assign if_id_instr   = ifid_q.instr;
    assign if_id_rs1_idx = ifid_q.instr[19:15];
    assign if_id_rs2_idx = ifid_q.instr[24:20];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model, fetch scoreboard,
// hand sequences for stall/redirect/reset and a redirect-target table.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [4:0]  if_id_rs1_idx;
    logic [4:0]  if_id_rs2_idx;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_rs1_idx  (if_id_rs1_idx),
        .if_id_rs2_idx  (if_id_rs2_idx)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[29:0], 2'b11} ^ 32'h1234_5000;
    endfunction

    // Memory: grants at once, answers lat cycles after the grant.
    int          lat = 1;
    logic        pending;
    int          wcnt;
    logic [31:0] paddr;

    assign imem_gnt    = imem_req;
    assign imem_rvalid = pending && (wcnt == 0);
    assign imem_rdata  = memf(paddr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            wcnt    <= 0;
            paddr   <= '0;
        end else begin
            if (imem_rvalid) pending <= 1'b0;
            else if (pending && wcnt != 0) wcnt <= wcnt - 1;
            if (imem_req && imem_gnt) begin
                pending <= 1'b1;
                wcnt    <= lat - 1;
                paddr   <= imem_addr;
            end
        end
    end

    // Scoreboard: each granted fetch is expected in IF/ID in order;
    // a redirect discards everything not yet in IF/ID.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (redirect_valid) begin
            exp_q.delete();
        end else if (imem_req && imem_gnt) begin
            exp_q.push_back('{imem_addr, memf(imem_addr)});
        end
    end

    logic        prev_v = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_in = '0;

    always @(negedge clk) begin
        if (rst_n && if_id_valid &&
            (!prev_v || if_id_pc != prev_pc || if_id_instr != prev_in)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, none expected",
                         if_id_pc, if_id_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (if_id_pc !== e.pc || if_id_instr !== e.instr) begin
                    n_bad++;
                    $display("FAIL sb_load: got pc=%h instr=%h want pc=%h instr=%h",
                             if_id_pc, if_id_instr, e.pc, e.instr);
                end
            end
        end
        prev_v  = if_id_valid;
        prev_pc = if_id_pc;
        prev_in = if_id_instr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timeout, got timeout want event", name);
    endtask

    // Stops one cycle before the edge that grants addr.
    task automatic wait_grant(input logic [31:0] addr);
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (imem_req && imem_gnt && imem_addr == addr) ok = 1;
            else tick();
        end
        if (!ok) timeout("wait_grant");
    endtask

    task automatic wait_req();
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (imem_req) ok = 1;
            else tick();
        end
        if (!ok) timeout("wait_req");
    endtask

    task automatic wait_load(input logic [31:0] pc);
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (if_id_valid && if_id_pc == pc) ok = 1;
            else tick();
        end
        if (!ok) timeout("wait_load");
    endtask

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] addr;
        logic [31:0] next;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
        tbl[1] = '{32'h0000_2002, 32'h0000_2000, 32'h0000_2004};
        tbl[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[3] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0004};
        tbl[4] = '{32'h5555_5557, 32'h5555_5554, 32'h5555_5558};

        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
        chk("rst_pc", if_id_pc, 32'd0);
        chk("rst_instr", if_id_instr, NOP);

        // First fetch, 1-cycle memory
        rst_n = 1'b1;
        #1;
        chk("t1_req", {31'b0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'd0);
        tick();
        chk("t1_wait_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("t1_valid", {31'b0, if_id_valid}, 32'd1);
        chk("t1_pc", if_id_pc, 32'd0);
        chk("t1_instr", if_id_instr, 32'h0050_0093);
        chk("t1_rs1", {27'b0, if_id_rs1_idx}, 32'd0);
        chk("t1_rs2", {27'b0, if_id_rs2_idx}, 32'd5);
        chk("t1_next", imem_addr, 32'd4);

        // Stall across a slow fetch of pc=8
        wait_grant(32'd8);
        lat   = 3;
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_hold_pc", if_id_pc, 32'd4);
            chk("t2_no_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("t2_pc", if_id_pc, 32'd8);
        chk("t2_instr", if_id_instr, memf(32'd8));
        chk("t2_next", imem_addr, 32'd12);

        // Redirect in WAIT, stale response two cycles later
        wait_grant(32'd12);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("t3_valid", {31'b0, if_id_valid}, 32'd0);
        chk("t3_instr", if_id_instr, NOP);
        chk("t3_drop_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("t3_drop_req2", {31'b0, imem_req}, 32'd0);
        tick();
        chk("t3_req", {31'b0, imem_req}, 32'd1);
        chk("t3_addr", imem_addr, 32'h100);
        lat = 1;

        // Redirect and stall together flush a valid IF/ID
        wait_load(32'h100);
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        chk("t4_valid", {31'b0, if_id_valid}, 32'd0);
        chk("t4_instr", if_id_instr, NOP);
        chk("t4_rs1", {27'b0, if_id_rs1_idx}, 32'd0);

        // Redirect targets: alignment and PC wrap
        for (int i = 0; i < 5; i++) begin
            redirect_valid = 1'b1;
            redirect_pc    = tbl[i].rpc;
            tick();
            redirect_valid = 1'b0;
            wait_req();
            chk("tbl_addr", imem_addr, tbl[i].addr);
            wait_load(tbl[i].addr);
            chk("tbl_instr", if_id_instr, memf(tbl[i].addr));
            chk("tbl_next", imem_addr, tbl[i].next);
        end

        // Asynchronous reset in the middle of a WAIT
        lat = 3;
        wait_req();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", {31'b0, if_id_valid}, 32'd0);
        chk("t6_instr", if_id_instr, NOP);
        chk("t6_req", {31'b0, imem_req}, 32'd0);
        lat = 1;
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6_rel_req", {31'b0, imem_req}, 32'd1);
        chk("t6_rel_addr", imem_addr, 32'd0);
        wait_load(32'd0);
        chk("t6_instr0", if_id_instr, 32'h0050_0093);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage RV32I core.
- Owns the PC and issues one-outstanding instruction-memory requests (req/gnt, then rvalid).
- Holds IF/ID while the load-use hazard unit asserts stall, and flushes it on an EX-stage branch/jump redirect.
- Drives the IF/ID rs1/rs2 indices consumed by the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) loaded on reset/flush.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  from hazard unit; 1 = hold PC and IF/ID.
- redirect_valid  in  1  taken branch/jump resolved in EX.
- redirect_pc  in  32  target PC; bits [1:0] are forced to 0 internally.
- imem_req  out  1  request valid; held until imem_gnt.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; at most one per granted request, earliest 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  32  PC of the IF/ID instruction.
- if_id_instr  out  32  IF/ID instruction.
- if_id_rs1_idx  out  5  if_id_instr[19:15].
- if_id_rs2_idx  out  5  if_id_instr[24:20].

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=REQ, imem_req=0 during reset, if_id_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR, rs1/rs2 idx=0, hold buffer empty.
- All if_id_* outputs are registered. rs1/rs2 indices are slices of the registered instruction.
- State REQ:
  - imem_req=1, imem_addr=pc.
  - On gnt without redirect: go to WAIT.
  - On gnt with redirect in the same cycle: pc<=redirect_pc, go to DROP.
  - On redirect without gnt: pc<=redirect_pc, stay in REQ. The new address appears next cycle.
- State WAIT:
  - On rvalid with stall=0: load IF/ID (valid=1, pc, rdata), pc<=pc+4, go to REQ.
  - On rvalid with stall=1: capture {pc, rdata} in the hold buffer, go to HOLD.
- State HOLD:
  - When stall=0: move the buffer into IF/ID, pc<=pc+4, go to REQ.
- State DROP:
  - Wait for rvalid, discard it, go to REQ. pc already holds the redirect target.
- Stall:
  - IF/ID, pc and the hold buffer are unchanged while stall=1.
  - An outstanding request still completes into the hold buffer.
- Flush (redirect_valid=1): IF/ID gets valid=0 and instr=NOP_INSTR next edge. Priority order is redirect > stall > load.
- Redirect in WAIT:
  - Without rvalid: go to DROP.
  - With rvalid in the same cycle: discard the data, go to REQ.
- Redirect in HOLD: discard the buffer, pc<=redirect_pc, go to REQ.
- Redirect in DROP: pc<=redirect_pc, stay in DROP.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Best-case throughput: one instruction per 2 cycles (REQ→WAIT→REQ) with 1-cycle memory.
- imem_rvalid outside WAIT/DROP is a protocol error and is ignored.
- Reset mid-request: the state machine returns to REQ. The memory model must also be reset.

Decomposition:
- Shared package core_pkg:
  - fetch_state_e enum (REQ, WAIT, HOLD, DROP).
  - NOP_INSTR constant.
  - XLEN=32.
  - if_id_t struct {valid, pc, instr}.
- One sub-module, if_id_reg: the IF/ID register with load/hold/flush controls and NOP reset value.
- Everything else (PC register, FSM, hold buffer) stays in fetch_stage.

Test Plan:
1. Reset release, memory gnt immediate, rvalid after 1 cycle, rdata=32'h0050_0093 → imem_addr=0 in cycle 1. if_id_valid=1, if_id_pc=0, if_id_instr=32'h0050_0093, rs1=0, rs2=5 two cycles later. Next imem_addr=4.
2. stall=1 for 3 cycles while a fetch of pc=8 is in WAIT; rvalid arrives → if_id_* unchanged during the stall. The buffered instruction at pc=8 appears the cycle after stall drops. No request is issued until then.
3. redirect_valid=1, redirect_pc=32'h100 while in WAIT; the stale rvalid arrives 2 cycles later → stale data is never in IF/ID, and if_id_valid=0 the cycle after the redirect. Next imem_addr=32'h100.
4. redirect and stall both 1 in the same cycle with a valid IF/ID → IF/ID is flushed (valid=0, instr=32'h0000_0013). Flush beats stall.
5. redirect_pc=32'h103 → imem_addr=32'h100.
6. PC=32'hFFFF_FFFC, fetch completes → next imem_addr=0. Separately, rst_n=0 asynchronously mid-WAIT → if_id_valid=0 immediately. After release, imem_addr=RESET_PC.
